// File: rtl/sobel_3x3.sv
// rtl/sobel_3x3.sv - 3x3 Sobel gradient magnitude with two-stage pipeline.
// Optional edge flag output enabled by defining SOBEL_THRESHOLD_EN.
module sobel_3x3 #(
    parameter int LINE_WIDTH = 76,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             sof,
    input  logic [PIX_W-1:0] in_top,
    input  logic [PIX_W-1:0] in_mid,
    input  logic [PIX_W-1:0] in_bot,
    input  logic [PIX_W-1:0] threshold,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_mag,
    output logic             out_edge
);
    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int GW    = PIX_W + 3;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [GW-1:0]    PIX_MAX  = GW'((1 << PIX_W) - 1);

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] m);
        return (m > PIX_MAX) ? {PIX_W{1'b1}} : m[PIX_W-1:0];
    endfunction

    // win[row][col]: row 0=top,1=mid,2=bot; col 0=left,1=centre,2=right
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [1:0]       row_q, row_d, cur_row;
    logic             qual_q, qual_d;
    logic             v1_q, v1_d;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [GW-1:0]    abs_x, abs_y;
    logic [GW-1:0]    mag_q, mag_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        win_d   = win_q;
        col_d   = col_q;
        row_d   = row_q;
        qual_d  = 1'b0;
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? 2'd0 : row_q;
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = in_top;
            win_d[1][2] = in_mid;
            win_d[2][2] = in_bot;
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            qual_d = (cur_col >= COL_W'(2)) && (cur_row == 2'd2);
        end
    end

    // Stage 1 reads the window registered on the qualifying edge.
    always_comb begin
        v1_d = qual_q;
        gx_d = gx_q;
        gy_d = gy_q;
        if (qual_q) begin
            gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
                 - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
            gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
                 - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
        end
    end

    always_comb begin
        abs_x       = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_y       = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag_d       = v1_q ? (abs_x + abs_y) : mag_q;
        out_valid_d = v1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q       <= '0;
            row_q       <= 2'd0;
            qual_q      <= 1'b0;
            v1_q        <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            col_q       <= col_d;
            row_q       <= row_d;
            qual_q      <= qual_d;
            v1_q        <= v1_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mag   = sat(mag_q);

`ifdef SOBEL_THRESHOLD_EN
    logic edge_q, edge_d;

    always_comb begin
        edge_d = v1_q ? (sat(mag_d) >= threshold) : edge_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign out_edge = edge_q;
`else
    logic unused_threshold;
    assign unused_threshold = |threshold;
    assign out_edge         = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_3x3.sv
// tb/tb_sobel_3x3.sv - directed self-checking bench for sobel_3x3.
module tb_sobel_3x3;
    localparam int LW = 76;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       sof;
    logic [7:0] in_top, in_mid, in_bot, threshold;
    logic       out_valid;
    logic [7:0] out_mag;
    logic       out_edge;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int obs_mag[$], obs_edge[$], obs_cyc[$];
    int exp_mag[$], exp_cyc[$];

    sobel_3x3 #(.LINE_WIDTH(LW), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof),
        .in_top(in_top), .in_mid(in_mid), .in_bot(in_bot), .threshold(threshold),
        .out_valid(out_valid), .out_mag(out_mag), .out_edge(out_edge)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_mag.push_back(int'(out_mag));
            obs_edge.push_back(int'(out_edge));
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input logic [31:0] observed, input logic [31:0] expected, input string tag);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // kind 0: flat 100; kind 1: vertical step at col 38; kind 2: ramp 2*col + 10*row
    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c >= 38) ? 8'd255 : 8'd0;
            default: return 8'(2 * c + 10 * (r + 2));
        endcase
    endfunction

    function automatic int exp_of(input int kind, input int c);
        case (kind)
            0:       return 0;
            1:       return (c == 38 || c == 39) ? 255 : 0;
            default: return 96;
        endcase
    endfunction

    function automatic int edge_of(input int m);
`ifdef SOBEL_THRESHOLD_EN
        return (m >= 128) ? 1 : 0;
`else
        return (m < 0) ? 1 : 0;
`endif
    endfunction

    task automatic send(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                        input logic s, input bit q, input int em);
        in_valid = 1'b1;
        sof      = s;
        in_top   = t;
        in_mid   = m;
        in_bot   = b;
        @(negedge clk);
        if (q) begin
            exp_cyc.push_back(cyc + 2);
            exp_mag.push_back(em);
        end
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic send_px(input int kind, input int r, input int c, input logic s, input bit q);
        send(pix(kind, r - 2, c), pix(kind, r - 1, c), pix(kind, r, c), s, q, exp_of(kind, c));
    endtask

    task automatic send_frame(input int kind, input int nrows, input bit gap, input bit first_sof);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < LW; c++) begin
                send_px(kind, r, c, first_sof && r == 0 && c == 0, r >= 2 && c >= 2);
                if (gap) @(negedge clk);
            end
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        repeat (4) @(negedge clk);
        chk(obs_mag.size(), exp_mag.size(), {tag, "_count"});
        n = (obs_mag.size() < exp_mag.size()) ? obs_mag.size() : exp_mag.size();
        for (int i = 0; i < n; i++) begin
            chk(obs_mag[i], exp_mag[i], {tag, "_mag"});
            chk(obs_cyc[i], exp_cyc[i], {tag, "_cycle"});
            chk(obs_edge[i], edge_of(exp_mag[i]), {tag, "_edge"});
        end
        obs_mag.delete();
        obs_edge.delete();
        obs_cyc.delete();
        exp_mag.delete();
        exp_cyc.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sof       = 1'b0;
        in_top    = '0;
        in_mid    = '0;
        in_bot    = '0;
        threshold = 8'd128;
        repeat (3) @(negedge clk);
        chk(out_valid, 0, "reset_valid");
        chk(out_mag, 0, "reset_mag");
        chk(out_edge, 0, "reset_edge");
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid, 0, "post_reset_valid");

        send_frame(0, 4, 1'b0, 1'b1);
        check_stream("uniform");

        send_frame(1, 3, 1'b0, 1'b1);
        check_stream("step");

        send_frame(2, 3, 1'b0, 1'b1);
        check_stream("ramp");
        repeat (5) @(negedge clk);
        chk(out_mag, 96, "hold_mag");
        chk(out_valid, 0, "hold_valid");

        send_frame(2, 3, 1'b1, 1'b1);
        check_stream("ramp_gap");

        // sof mid-line at col 40 of row 3
        send_frame(0, 3, 1'b0, 1'b1);
        for (int c = 0; c < 40; c++) send_px(0, 3, c, 1'b0, c >= 2);
        send_px(0, 0, 0, 1'b1, 1'b0);
        for (int c = 1; c < LW; c++) send_px(0, 0, c, 1'b0, 1'b0);
        for (int c = 0; c < LW; c++) send_px(0, 1, c, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) send_px(0, 2, c, 1'b0, c >= 2);
        check_stream("sof_mid");

        // reset with cols 10 and 11 of row 2 still in flight
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < LW; c++) send_px(2, r, c, r == 0 && c == 0, 1'b0);
        end
        for (int c = 0; c < 12; c++) send_px(2, 2, c, 1'b0, c >= 2 && c <= 9);
        #2;
        rst = 1'b1;
        #1;
        chk(out_valid, 0, "rst_async_valid");
        chk(out_mag, 0, "rst_async_mag");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(2, 3, 1'b0, 1'b0);
        check_stream("rst_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_3x3.md
SOBEL_3X3 -- requirements
Module: sobel_3x3

Interface
- REQ-001: Parameter LINE_WIDTH, default 76, gives pixels per image line; legal range 3..127.
- REQ-002: Parameter PIX_W, default 8, gives pixel width in bits.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: rst  input  1  reset, asynchronous and active-high.
- REQ-005: in_valid  input  1  qualifies in_top, in_mid, in_bot and sof this cycle.
- REQ-006: sof  input  1  start of frame; meaningful only with in_valid.
- REQ-007: in_top  input  PIX_W  pixel from the line two rows above, taken from the upstream 76-deep line buffer tap.
- REQ-008: in_mid  input  PIX_W  pixel from the line one row above, taken from the line buffer tap.
- REQ-009: in_bot  input  PIX_W  current-row pixel.
- REQ-010: threshold  input  PIX_W  edge threshold; used only when SOBEL_THRESHOLD_EN is defined.
- REQ-011: out_valid  output  1  out_mag and out_edge are valid this cycle.
- REQ-012: out_mag  output  PIX_W  saturated gradient magnitude.
- REQ-013: out_edge  output  1  binary edge flag.

Function
- REQ-014: Window is 3x3 registers [row T,M,B][col L,C,R]; on in_valid: L<=C, C<=R, R<=input column; window holds when in_valid=0.
- REQ-015: col counter 0..LINE_WIDTH-1; it advances on each in_valid and wraps to 0 after LINE_WIDTH-1.
- REQ-016: row counter increments on col wrap and saturates at 2.
- REQ-017: in_valid with sof=1 treats the pixel as col=0, row=0; the next pixel is col=1. This applies mid-line too, and the window contents are not cleared.
- REQ-018: A window qualifies when the accepted pixel has col>=2 and row>=2, giving LINE_WIDTH-2 outputs per line from row 2 onward.
- REQ-019: Stage 1 (cycle after a qualifying in_valid) registers the two gradients and a valid bit; both gradients are signed, PIX_W+3 bits.
  - Gx = (TR+2MR+BR)-(TL+2ML+BL).
  - Gy = (BL+2BC+BR)-(TL+2TC+TR).
- REQ-020: Stage 2 registers mag=|Gx|+|Gy| (PIX_W+3 bits unsigned, no overflow), then saturates: out_mag = min(mag, 2^PIX_W-1).
- REQ-021: out_valid asserts exactly 2 clocks after the qualifying in_valid edge, for one cycle per qualifying pixel.
- REQ-022: The pipeline is free-running with no backpressure; back-to-back in_valid yields back-to-back out_valid.
- REQ-023: out_mag and out_edge hold their last value while out_valid=0.

Reset
- REQ-024: rst asserted clears all of the following asynchronously, including mid-frame:
  - window registers, Gx, Gy and mag;
  - col=0, row=0;
  - both valid bits;
  - out_valid=0, out_mag=0, out_edge=0.
- REQ-025: After rst deasserts, the first in_valid is treated as col=0, row=0 whether or not sof is set.

Configuration
- REQ-026: With SOBEL_THRESHOLD_EN defined, stage 2 also registers out_edge = (saturated mag >= threshold), aligned with out_mag.
- REQ-027: With SOBEL_THRESHOLD_EN undefined, out_edge is constant 0, threshold is unused, and no comparator is built.

Verification
- REQ-028: Uniform image (all pixels 100), LINE_WIDTH=76, 4 lines -> first out_valid at row 2, col 2; 74 outputs per line from row 2; every out_mag=0.
- REQ-029: Vertical step (cols 0..37 =0, 38..75 =255) -> Gx=1020, out_mag=255 at the two step-straddling windows; all other windows give out_mag=0.
- REQ-030: Pixel ramp with in_valid toggling 1,0,1,0 -> outputs match the same ramp fed with continuous in_valid; each out_valid occurs 2 clocks after its qualifying input.
- REQ-031: sof pulsed at col 40 of row 3 -> no out_valid for the next two accepted pixels and none until row>=2 again.
- REQ-032: rst asserted for 1 cycle mid-line with 2 outputs in flight -> out_valid=0 immediately and those 2 outputs are never emitted; the restart behaves as col=0, row=0.
- REQ-033: With SOBEL_THRESHOLD_EN defined and threshold=128, step image -> out_edge=1 where out_mag=255 and 0 where out_mag=0; with the macro undefined, out_edge stays 0.
